// File: rtl/key_led2_if.sv
// Board-pin bundle for the two-key / two-LED controller.
// The key inputs are active-low and the LED outputs are active-high.
interface key_led2_if;
  logic [1:0] key;
  logic [1:0] led;

  modport master (output key, input  led);
  modport slave  (input  key, output led);
endinterface

// File: rtl/key_led2.sv
// Two-key, two-LED demo controller: synchronise, debounce, decode the key combination
// into one of four display modes and drive registered LEDs.
module key_led2 #(
  parameter int DEBOUNCE_CNT  = 1_000_000,
  parameter int BLINK_CNT_MAX = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  key_led2_if.slave  pins
);

  localparam int DB_W = (DEBOUNCE_CNT  > 1) ? $clog2(DEBOUNCE_CNT)  : 1;
  localparam int BL_W = (BLINK_CNT_MAX > 1) ? $clog2(BLINK_CNT_MAX) : 1;

  typedef enum logic [1:0] {
    MODE_ON    = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_ALT   = 2'b10,
    MODE_IDLE  = 2'b11
  } mode_t;

  logic [1:0]      key_sync_p0, key_sync_p1;
  logic [1:0]      key_db_p2;
  logic [DB_W-1:0] db_cnt_p2 [2];
  logic [1:0]      key_db_p3;
  logic [BL_W-1:0] blink_cnt_p3, blink_cnt_nxt;
  logic            phase_p3, phase_nxt;
  logic [1:0]      led_p3, led_nxt;
  logic            mode_chg;
  mode_t           mode;

  // p0/p1: two-flop synchroniser; p2: per-bit debounce
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_sync_p0 <= 2'b11;
      key_sync_p1 <= 2'b11;
      key_db_p2   <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_p2[i] <= '0;
    end else begin
      key_sync_p0 <= pins.key;
      key_sync_p1 <= key_sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (key_sync_p1[i] == key_db_p2[i]) begin
          db_cnt_p2[i] <= '0;
        end else if (db_cnt_p2[i] == DB_W'(DEBOUNCE_CNT - 1)) begin
          key_db_p2[i] <= key_sync_p1[i];
          db_cnt_p2[i] <= '0;
        end else begin
          db_cnt_p2[i] <= db_cnt_p2[i] + DB_W'(1);
        end
      end
    end
  end

  assign mode     = mode_t'(key_db_p2);
  assign mode_chg = (key_db_p2 != key_db_p3);

  // LED is decoded from the phase being loaded this cycle, so a fresh mode starts on phase 0
  always_comb begin
    blink_cnt_nxt = blink_cnt_p3;
    phase_nxt     = phase_p3;
    if (mode_chg || mode == MODE_IDLE || mode == MODE_ON) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (blink_cnt_p3 == BL_W'(BLINK_CNT_MAX - 1)) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase_p3;
    end else begin
      blink_cnt_nxt = blink_cnt_p3 + BL_W'(1);
    end

    led_nxt = 2'b00;
    case (mode)
      MODE_IDLE:  led_nxt = 2'b00;
      MODE_ALT:   led_nxt = phase_nxt ? 2'b10 : 2'b01;
      MODE_BLINK: led_nxt = phase_nxt ? 2'b00 : 2'b11;
      MODE_ON:    led_nxt = 2'b11;
      default:    led_nxt = 2'b00;
    endcase
  end

  // p3: blink timer, mode history and LED register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_db_p3    <= 2'b11;
      blink_cnt_p3 <= '0;
      phase_p3     <= 1'b0;
      led_p3       <= 2'b00;
    end else begin
      key_db_p3    <= key_db_p2;
      blink_cnt_p3 <= blink_cnt_nxt;
      phase_p3     <= phase_nxt;
      led_p3       <= led_nxt;
    end
  end

  assign pins.led = led_p3;

endmodule

// File: tb/tb_key_led2.sv
// Bench for key_led2: directed scenarios then randomized key activity, each cycle
// compared against a behavioural model built from mode-entry time and hold durations.
module tb_key_led2;
  localparam int DEB = 4;
  localparam int BLK = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  key_led2_if pins();

  key_led2 #(.DEBOUNCE_CNT(DEB), .BLINK_CNT_MAX(BLK)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .pins    (pins)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  logic [1:0] m_s1, m_s2, m_db, m_prev, m_led;
  int         m_run [2];
  int         cyc   = 0;
  int         entry = 0;

  task automatic model_edge(input logic [1:0] k, input logic r);
    logic [1:0] db_new;
    int ph;
    cyc++;
    if (r) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b11; m_prev = 2'b11;
      m_run[0] = 0; m_run[1] = 0;
      m_led = 2'b00;
      entry = cyc;
    end else begin
      // the LED reflects the mode accepted one cycle earlier; a new mode restarts timing
      if (m_db != m_prev) entry = cyc;
      ph = ((cyc - entry) / BLK) % 2;
      case (m_db)
        2'b11:   m_led = 2'b00;
        2'b10:   m_led = (ph != 0) ? 2'b10 : 2'b01;
        2'b01:   m_led = (ph != 0) ? 2'b00 : 2'b11;
        default: m_led = 2'b11;
      endcase
      // a key bit is accepted once its synced level has disagreed for DEB straight cycles
      db_new = m_db;
      for (int b = 0; b < 2; b++) begin
        if (m_s2[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            db_new[b] = m_s2[b];
            m_run[b]  = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_prev = m_db;
      m_db   = db_new;
      m_s2   = m_s1;
      m_s1   = k;
    end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] k, input logic r, input string tag);
    @(negedge clk);
    pins.key = k;
    rst      = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
    check(tag, pins.led, m_led);
  endtask

  initial begin
    logic [1:0] rk;
    int         hold;
    logic       rr;

    pins.key = 2'b00;
    m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b11; m_prev = 2'b11; m_led = 2'b00;
    m_run[0] = 0; m_run[1] = 0;

    // reset held with both keys pressed
    repeat (10) step(2'b00, 1'b1, "reset");
    check("reset_led", pins.led, 2'b00);

    // released keys: idle forever
    repeat (20) step(2'b11, 1'b0, "idle");
    check("idle_led", pins.led, 2'b00);

    // key0 pressed: ALT
    repeat (6) step(2'b10, 1'b0, "alt_entry");
    check("alt_before", pins.led, 2'b00);
    step(2'b10, 1'b0, "alt_entry");
    check("alt_first", pins.led, 2'b01);
    repeat (5) step(2'b10, 1'b0, "alt_run");
    check("alt_toggle1", pins.led, 2'b10);
    repeat (5) step(2'b10, 1'b0, "alt_run");
    check("alt_toggle2", pins.led, 2'b01);

    // key1 pressed: BLINK
    repeat (7) step(2'b01, 1'b0, "blink_entry");
    check("blink_first", pins.led, 2'b11);
    repeat (5) step(2'b01, 1'b0, "blink_run");
    check("blink_toggle1", pins.led, 2'b00);
    repeat (5) step(2'b01, 1'b0, "blink_run");
    check("blink_toggle2", pins.led, 2'b11);

    // both pressed: ON, short release glitch ignored
    repeat (7) step(2'b00, 1'b0, "on_entry");
    check("on_first", pins.led, 2'b11);
    repeat (2) step(2'b11, 1'b0, "glitch");
    repeat (12) step(2'b00, 1'b0, "on_hold");
    check("on_glitch", pins.led, 2'b11);

    // reset in the middle of BLINK while lit
    repeat (7) step(2'b01, 1'b0, "blink2_entry");
    check("blink2_lit", pins.led, 2'b11);
    step(2'b01, 1'b1, "mid_reset");
    check("mid_reset_led", pins.led, 2'b00);
    repeat (6) step(2'b01, 1'b0, "post_reset");
    check("post_reset_wait", pins.led, 2'b00);
    step(2'b01, 1'b0, "post_reset");
    check("post_reset_first", pins.led, 2'b11);
    repeat (5) step(2'b01, 1'b0, "post_reset_run");
    check("post_reset_toggle", pins.led, 2'b00);

    // randomized key activity with occasional reset pulses
    for (int n = 0; n < 80; n++) begin
      rk   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        rr = ($urandom_range(0, 59) == 0);
        step(rk, rr, "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
